slave_fifo_tx: RTL and testbench
================================

// Module: slave_fifo_tx
// PURPOSE
//  Drain stage behind the slave-FIFO buffer: pops words from fifo (read_busy/dout/fifo_empty)
//  and writes them onto the FX3 GPIF-II slave-FIFO write bus. Frames data into packets of
//  BURST_LEN words; commits short packets with PKTEND after IDLE_TIMEOUT idle cycles or disable.
// PARAMETERS
//  DATA_WIDTH    32   width of fifo data and fx3_data
//  BURST_LEN     256  words per full packet (FX3 DMA buffer size / word size), >=2
//  IDLE_TIMEOUT  16   consecutive no-pop cycles before a short packet is committed, >=1
// PORTS
//  fifo_clk      in   1            single clock; all logic on posedge
//  rst_n         in   1            asynchronous active-low reset
//  enable        in   1            1 = stream; 0 = stop popping, close open packet
//  fifo_dout     in   DATA_WIDTH   fifo read data, valid cycle after fifo_read
//  fifo_empty    in   1            fifo empty flag (registered)
//  fifo_read     out  1            pop strobe to fifo read_busy (combinational)
//  fx3_full_n    in   1            FX3 FLAGA watermark, 0 = stop writing
//  fx3_data      out  DATA_WIDTH   registered write data to FX3
//  fx3_slwr_n    out  1            registered write strobe, active low
//  fx3_pktend_n  out  1            registered packet-end strobe, active low
//  busy          out  1            1 when state != IDLE or words in flight
//  pkt_count     out  16           packets committed (full + short), wraps at 16'hFFFF
// BEHAVIOUR
//  Reset: fifo_read=0, fx3_data=0, fx3_slwr_n=1, fx3_pktend_n=1, busy=0, pkt_count=0,
//   state=IDLE, word_cnt=0, idle_cnt=0, pipeline valids cleared; in-flight words discarded.
//  Pipeline: pop at cycle N -> pop_d at N+1 (fifo_dout valid) -> fx3_slwr_n=0 with
//   fx3_data=fifo_dout at N+2. Fixed 2-cycle latency; back-to-back pops give gapless writes.
//  word_cnt ($clog2(BURST_LEN+1) bits): words popped in current packet.
//  fifo_read = (state==STREAM) & enable & ~fifo_empty & fx3_full_n & (word_cnt<BURST_LEN).
//  Never pops when fifo_empty=1 (no underflow); fx3_pktend_n and fx3_slwr_n never both 0.
//  FSM:
//   IDLE:   enable=1 -> STREAM.
//   STREAM: pop increments word_cnt, clears idle_cnt. No pop & word_cnt>0 -> idle_cnt++.
//           pop making word_cnt==BURST_LEN -> GAP.
//           idle_cnt==IDLE_TIMEOUT-1 with no pop, or enable=0 with word_cnt>0 -> DRAIN.
//           enable=0 with word_cnt==0 -> IDLE (after pipeline empties).
//   GAP:    wait pipeline empty (last slwr done), +1 cycle; word_cnt=0, pkt_count++
//           (full packet auto-committed by FX3, no PKTEND) -> STREAM, or IDLE if enable=0.
//   DRAIN:  no pops; wait until pipeline empty -> PKTEND.
//   PKTEND: fx3_pktend_n=0 one cycle, fx3_slwr_n=1; word_cnt=0, idle_cnt=0, pkt_count++
//           -> STREAM if enable else IDLE.
//  fx3_full_n=0: pops stop same cycle; up to 2 in-flight words still written. FX3
//   watermark must allow >=2 writes after FLAGA falls. idle_cnt does not count while
//   fx3_full_n=0 (backpressure never triggers a short packet).
//  Simultaneous: last word reaching BURST_LEN with timeout or enable=0 -> GAP wins
//   (packet full, no PKTEND). enable toggling in GAP/DRAIN/PKTEND does not abort them.
//  Zero-length packets never generated (PKTEND only when word_cnt>0).
// TESTING
//  1) Preload 256 words 0..255, enable=1, full_n=1 -> 256 consecutive slwr_n=0 from
//     2 cycles after first pop, data 0..255 in order, no pktend, pkt_count=1.
//  2) Preload 5 words, enable=1 -> 5 writes, then pktend_n=0 once exactly 16 cycles
//     after last pop + pipeline drain, slwr_n=1 that cycle, pkt_count=1.
//  3) Stream 600 words with fx3_full_n low 10 cycles mid-burst -> pops stop same cycle,
//     <=2 extra writes, resume gapless; packets 256,256, then short 88 + pktend; pkt_count=3.
//  4) 10 words written, drop enable -> no further pops, pktend after drain, state IDLE,
//     busy=0; words left in fifo untouched.
//  5) Assert rst_n=0 mid-burst -> outputs immediately at reset values; after release,
//     idle with slwr_n=1, pktend_n=1, pkt_count=0.
//  6) Empty fifo with enable=1 for 1000 cycles -> fifo_read never 1, no pktend.

Source files
------------

// File: rtl/slave_fifo_tx.sv
// Drains words from the slave-FIFO buffer onto the FX3 GPIF-II slave-FIFO write bus,
// framing them into BURST_LEN packets and committing short packets with PKTEND.
module slave_fifo_tx #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BURST_LEN    = 256,
    parameter int unsigned IDLE_TIMEOUT = 16
) (
    input  logic                  fifo_clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    input  logic                  fx3_full_n,
    output logic [DATA_WIDTH-1:0] fx3_data,
    output logic                  fx3_slwr_n,
    output logic                  fx3_pktend_n,
    output logic                  busy,
    output logic [15:0]           pkt_count
);

    localparam int unsigned WCNT_W = $clog2(BURST_LEN + 1);
    localparam int unsigned ICNT_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] BURST_FULL = WCNT_W'(BURST_LEN);
    localparam logic [WCNT_W-1:0] BURST_LAST = WCNT_W'(BURST_LEN - 1);
    localparam logic [ICNT_W-1:0] IDLE_LAST  = ICNT_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_GAP,
        S_DRAIN,
        S_PKTEND
    } state_e;

    state_e                state_q, state_d;
    logic [WCNT_W-1:0]     word_cnt_q, word_cnt_d;
    logic [ICNT_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic [15:0]           pkt_cnt_q, pkt_cnt_d;
    logic                  pktend_n_q, pktend_n_d;
    logic                  busy_q, busy_d;
    logic                  pop_d_q;
    logic                  slwr_n_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  pop_c;
    logic                  pipe_empty_c;

    // Pop only while streaming with room in the packet and no FX3 backpressure.
    assign pop_c = (state_q == S_STREAM) & enable & ~fifo_empty & fx3_full_n
                   & (word_cnt_q < BURST_FULL);
    // Nothing popped and not yet written, and no write on the bus this cycle.
    assign pipe_empty_c = ~pop_d_q & slwr_n_q;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        idle_cnt_d = idle_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        pktend_n_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                word_cnt_d = '0;
                idle_cnt_d = '0;
                if (enable) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (pop_c) begin
                    word_cnt_d = word_cnt_q + WCNT_W'(1);
                    idle_cnt_d = '0;
                    if (word_cnt_q == BURST_LAST) state_d = S_GAP;
                end else if (!enable) begin
                    if (word_cnt_q != '0)   state_d = S_DRAIN;
                    else if (pipe_empty_c)  state_d = S_IDLE;
                end else if ((word_cnt_q != '0) && fx3_full_n) begin
                    // Backpressure freezes the idle counter so it never closes a packet.
                    if (idle_cnt_q == IDLE_LAST) state_d = S_DRAIN;
                    else                         idle_cnt_d = idle_cnt_q + ICNT_W'(1);
                end
            end
            S_GAP: begin
                if (pipe_empty_c) begin
                    word_cnt_d = '0;
                    idle_cnt_d = '0;
                    pkt_cnt_d  = pkt_cnt_q + 16'd1;
                    state_d    = enable ? S_STREAM : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (pipe_empty_c) begin
                    state_d    = S_PKTEND;
                    pktend_n_d = 1'b0;
                end
            end
            S_PKTEND: begin
                word_cnt_d = '0;
                idle_cnt_d = '0;
                pkt_cnt_d  = pkt_cnt_q + 16'd1;
                state_d    = enable ? S_STREAM : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE) | pop_c | pop_d_q;
    end

    always_ff @(posedge fifo_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            word_cnt_q <= '0;
            idle_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            pktend_n_q <= 1'b1;
            busy_q     <= 1'b0;
            pop_d_q    <= 1'b0;
            slwr_n_q   <= 1'b1;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            pktend_n_q <= pktend_n_d;
            busy_q     <= busy_d;
            pop_d_q    <= pop_c;
            slwr_n_q   <= ~pop_d_q;
            if (pop_d_q) data_q <= fifo_dout;
        end
    end

    assign fifo_read    = pop_c;
    assign fx3_data     = data_q;
    assign fx3_slwr_n   = slwr_n_q;
    assign fx3_pktend_n = pktend_n_q;
    assign busy         = busy_q;
    assign pkt_count    = pkt_cnt_q;

endmodule

// File: tb/tb_slave_fifo_tx.sv
// Directed + randomized bench for slave_fifo_tx with a queue-based FIFO model and
// a write scoreboard checking data order, 2-cycle latency and packet framing.
module tb_slave_fifo_tx;

    localparam int DW = 32;
    localparam int BL = 256;
    localparam int IT = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_read;
    logic          fx3_full_n = 1'b1;
    logic [DW-1:0] fx3_data;
    logic          fx3_slwr_n;
    logic          fx3_pktend_n;
    logic          busy;
    logic [15:0]   pkt_count;

    slave_fifo_tx #(.DATA_WIDTH(DW), .BURST_LEN(BL), .IDLE_TIMEOUT(IT)) dut (
        .fifo_clk     (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_read    (fifo_read),
        .fx3_full_n   (fx3_full_n),
        .fx3_data     (fx3_data),
        .fx3_slwr_n   (fx3_slwr_n),
        .fx3_pktend_n (fx3_pktend_n),
        .busy         (busy),
        .pkt_count    (pkt_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] expq[$];
    int popq[$];
    int total_wr, total_pop, pktend_seen, wr_in_pkt;
    int first_wr_cyc, last_wr_cyc, last_pop_cyc, last_pktend_cyc, full_low_wr;
    bit mon_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-flag FIFO model feeding the DUT.
    always @(posedge clk) begin
        if (fifo_read && rst_n && fq.size() > 0) fifo_dout <= fq.pop_front();
        fifo_empty <= (fq.size() == 0);
    end

    // Bus monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("slwr_pktend_excl", 64'(fx3_slwr_n | fx3_pktend_n), 64'(1));
            if (fifo_read) begin
                check("pop_nonempty", 64'(fifo_empty), 64'(0));
                check("pop_full_n", 64'(fx3_full_n), 64'(1));
                check("pop_enable", 64'(enable), 64'(1));
                popq.push_back(cyc);
                total_pop++;
                last_pop_cyc = cyc;
            end
            if (!fx3_slwr_n) begin
                if (expq.size() == 0 || popq.size() == 0) begin
                    check("wr_unexpected", 64'(1), 64'(0));
                end else begin
                    check("wr_data", 64'(fx3_data), 64'(expq.pop_front()));
                    check("wr_latency", 64'(cyc), 64'(popq.pop_front() + 2));
                end
                if (total_wr == 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                total_wr++;
                wr_in_pkt++;
                if (!fx3_full_n) full_low_wr++;
                if (wr_in_pkt == BL) wr_in_pkt = 0;
            end
            if (!fx3_pktend_n) begin
                check("short_pkt_len", 64'((wr_in_pkt > 0) && (wr_in_pkt < BL)), 64'(1));
                wr_in_pkt = 0;
                pktend_seen++;
                last_pktend_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        fq.delete();
        expq.delete();
        popq.delete();
        total_wr = 0; total_pop = 0; pktend_seen = 0; wr_in_pkt = 0;
        first_wr_cyc = 0; last_wr_cyc = 0; last_pop_cyc = 0; last_pktend_cyc = 0;
        full_low_wr = 0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        enable = 1'b0;
        fx3_full_n = 1'b1;
        rst_n = 1'b0;
        repeat (3) step();
        clear_model();
        rst_n = 1'b1;
        step();
        mon_en = 1'b1;
    endtask

    task automatic preload(input int n, input bit rnd);
        logic [DW-1:0] v;
        for (int i = 0; i < n; i++) begin
            v = rnd ? DW'($urandom) : DW'(i);
            fq.push_back(v);
            expq.push_back(v);
        end
        step();
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k = 0;
        while (total_wr < n && k < budget) begin
            step();
            k++;
        end
        check("wait_writes_timeout", 64'(total_wr >= n), 64'(1));
    endtask

    task automatic run_bp(input int n, input int low_after, input int low_len);
        int pops_at_low;
        do_reset();
        preload(n, 1'b1);
        enable = 1'b1;
        wait_writes(low_after, 4 * n + 100);
        fx3_full_n = 1'b0;
        full_low_wr = 0;
        pops_at_low = total_pop;
        repeat (low_len) step();
        check("bp_inflight_le2", 64'(full_low_wr <= 2), 64'(1));
        check("bp_no_pops", 64'(total_pop), 64'(pops_at_low));
        fx3_full_n = 1'b1;
        wait_writes(n, 4 * n + 200);
        repeat (IT + 10) step();
        check("bp_pkt_count", 64'(pkt_count), 64'(n / BL + ((n % BL) != 0 ? 1 : 0)));
        check("bp_pktends", 64'(pktend_seen), 64'((n % BL) != 0 ? 1 : 0));
        check("bp_all_written", 64'(expq.size()), 64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, la, ll;
        // Reset values
        do_reset();
        check("rst_slwr_n", 64'(fx3_slwr_n), 64'(1));
        check("rst_pktend_n", 64'(fx3_pktend_n), 64'(1));
        check("rst_data", 64'(fx3_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_pkt_count", 64'(pkt_count), 64'(0));
        check("rst_fifo_read", 64'(fifo_read), 64'(0));

        // 1) One full packet of 0..255, committed without PKTEND
        preload(BL, 1'b0);
        enable = 1'b1;
        wait_writes(BL, 2000);
        repeat (IT + 10) step();
        check("full_pops", 64'(total_pop), 64'(BL));
        check("full_gapless", 64'(last_wr_cyc - first_wr_cyc), 64'(BL - 1));
        check("full_no_pktend", 64'(pktend_seen), 64'(0));
        check("full_pkt_count", 64'(pkt_count), 64'(1));
        check("full_all_written", 64'(expq.size()), 64'(0));

        // 2) Short packet closed by idle timeout
        do_reset();
        preload(5, 1'b1);
        enable = 1'b1;
        wait_writes(5, 200);
        repeat (IT + 10) step();
        check("short_pktend_once", 64'(pktend_seen), 64'(1));
        check("short_pktend_time", 64'(last_pktend_cyc), 64'(last_pop_cyc + IT + 2));
        check("short_pkt_count", 64'(pkt_count), 64'(1));
        check("short_busy_stream", 64'(busy), 64'(1));

        // 3) 600 words with a 10-cycle backpressure window, then randomized variants
        run_bp(600, 300, 10);
        for (int r = 0; r < 3; r++) begin
            n  = int'($urandom_range(20, 700));
            la = int'($urandom_range(1, n - 1));
            ll = int'($urandom_range(1, 30));
            run_bp(n, la, ll);
        end

        // 4) Disable after ~10 writes closes the packet and leaves the rest in the fifo
        do_reset();
        preload(40, 1'b1);
        enable = 1'b1;
        wait_writes(10, 200);
        enable = 1'b0;
        repeat (30) step();
        check("dis_pktend_once", 64'(pktend_seen), 64'(1));
        check("dis_busy", 64'(busy), 64'(0));
        check("dis_pkt_count", 64'(pkt_count), 64'(1));
        check("dis_pop_eq_wr", 64'(total_pop), 64'(total_wr));
        check("dis_fifo_left", 64'(fq.size()), 64'(40 - total_wr));
        if (fq.size() > 0 && expq.size() > 0)
            check("dis_fifo_head", 64'(fq[0]), 64'(expq[0]));
        check("dis_fifo_read", 64'(fifo_read), 64'(0));

        // 5) Asynchronous reset in the middle of the second packet
        do_reset();
        preload(300, 1'b1);
        enable = 1'b1;
        wait_writes(280, 1000);
        check("mid_pkt_count", 64'(pkt_count), 64'(1));
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_slwr_n", 64'(fx3_slwr_n), 64'(1));
        check("arst_pktend_n", 64'(fx3_pktend_n), 64'(1));
        check("arst_data", 64'(fx3_data), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_pkt_count", 64'(pkt_count), 64'(0));
        check("arst_fifo_read", 64'(fifo_read), 64'(0));
        repeat (2) step();
        enable = 1'b0;
        clear_model();
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (5) step();
        check("post_rst_slwr_n", 64'(fx3_slwr_n), 64'(1));
        check("post_rst_pktend_n", 64'(fx3_pktend_n), 64'(1));
        check("post_rst_pkt_count", 64'(pkt_count), 64'(0));
        check("post_rst_busy", 64'(busy), 64'(0));

        // 6) Enabled against an empty fifo: no pops, no zero-length packets
        do_reset();
        enable = 1'b1;
        repeat (1000) step();
        check("empty_no_pops", 64'(total_pop), 64'(0));
        check("empty_no_pktend", 64'(pktend_seen), 64'(0));
        check("empty_pkt_count", 64'(pkt_count), 64'(0));
        check("empty_busy", 64'(busy), 64'(1));

        enable = 1'b0;
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
